nibble_byte_assembler: RTL and testbench

// Downstream of the Hamming(7,4) decoder, upstream of the UART transmitter. Pairs decoded
// 4-bit nibbles into bytes, buffers them in a small FIFO and starts one transmitter frame
// per byte via an enable pulse, pacing on the transmitter busy flag. Flags or drops bytes

---
 rtl/nibble_byte_assembler.sv | 203 ++++++++++++++++++++
 tb/tb_nibble_byte_assembler.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_byte_assembler.sv
// Pairs decoded Hamming nibbles into bytes, buffers them in a small FIFO and
// starts one UART frame per byte, pacing on the transmitter busy flag.
`timescale 1ns/1ps
module nibble_byte_assembler #(
    parameter int LOW_FIRST  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_BAD   = 0,
    parameter int BUSY_WAIT  = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [3:0]                    i_nib_in,
    input  logic                          i_nib_valid,
    input  logic                          i_nib_corr,
    input  logic                          i_nib_uncorr,
    input  logic                          i_nib_sync,
    input  logic                          i_tx_busy,
    output logic [7:0]                    o_tx_byte,
    output logic                          o_tx_enable,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow,
    output logic [7:0]                    o_corr_cnt,
    output logic [7:0]                    o_drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] WAIT_END = CW'(BUSY_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t          r_state;
    state_t          w_next;
    logic            r_phase;
    logic [3:0]      r_first_nib;
    logic            r_first_bad;
    logic            r_pend_vld;
    logic [7:0]      r_pend_byte;
    logic            r_pend_bad;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [CW-1:0]   r_wait_cnt;
    logic [7:0]      r_tx_byte;
    logic            r_tx_enable;
    logic            r_overflow;
    logic [7:0]      r_corr_cnt;
    logic [7:0]      r_drop_cnt;

    logic            w_take_first;
    logic            w_complete;
    logic [7:0]      w_assembled;
    logic            w_push_req;
    logic            w_bad_drop;
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic            w_lost;

    // A sync pulse restarts pairing; a nibble arriving with it becomes the first half.
    assign w_take_first = i_nib_valid & (i_nib_sync | ~r_phase);
    assign w_complete   = i_nib_valid & ~i_nib_sync & r_phase;
    assign w_assembled  = (LOW_FIRST != 0) ? {i_nib_in, r_first_nib} : {r_first_nib, i_nib_in};

    assign w_bad_drop = r_pend_vld & r_pend_bad & (DROP_BAD != 0);
    assign w_push_req = r_pend_vld & ~w_bad_drop;
    assign w_pop      = (r_state == S_START);
    assign w_full     = (r_level == LVL_FULL);
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_lost     = w_push_req & w_full & ~w_pop;

    // Nibble pairing and the one-cycle staging register ahead of the FIFO.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_phase     <= 1'b0;
            r_first_nib <= 4'h0;
            r_first_bad <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_byte <= 8'h00;
            r_pend_bad  <= 1'b0;
        end else begin
            r_pend_vld <= w_complete;
            if (w_take_first) begin
                r_phase     <= 1'b1;
                r_first_nib <= i_nib_in;
                r_first_bad <= i_nib_uncorr;
            end else if (w_complete || i_nib_sync) begin
                r_phase <= 1'b0;
            end else begin
                r_phase <= r_phase;
            end
            if (w_complete) begin
                r_pend_byte <= w_assembled;
                r_pend_bad  <= r_first_bad | i_nib_uncorr;
            end else begin
                r_pend_byte <= r_pend_byte;
                r_pend_bad  <= r_pend_bad;
            end
        end
    end

    // Byte FIFO storage, pointers and occupancy.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {LW{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_pend_byte;
                r_wr_ptr        <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Transmit FSM state register and busy-rise timeout counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= {CW{1'b0}};
        end else begin
            r_state <= w_next;
            if (r_state == S_WAIT_HI) begin
                r_wait_cnt <= r_wait_cnt + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                r_wait_cnt <= {CW{1'b0}};
            end
        end
    end

    // Transmit FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if ((r_level != {LW{1'b0}}) && !i_tx_busy) w_next = S_START;
                else                                       w_next = S_IDLE;
            end
            S_START: w_next = S_WAIT_HI;
            S_WAIT_HI: begin
                if (i_tx_busy)                   w_next = S_WAIT_LO;
                else if (r_wait_cnt == WAIT_END) w_next = S_IDLE;
                else                             w_next = S_WAIT_HI;
            end
            S_WAIT_LO: begin
                if (!i_tx_busy) w_next = S_IDLE;
                else            w_next = S_WAIT_LO;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Registered transmitter handshake and status counters.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tx_byte   <= 8'h00;
            r_tx_enable <= 1'b0;
            r_overflow  <= 1'b0;
            r_corr_cnt  <= 8'h00;
            r_drop_cnt  <= 8'h00;
        end else begin
            r_tx_enable <= w_pop;
            r_tx_byte   <= w_pop ? r_mem[r_rd_ptr] : r_tx_byte;
            r_overflow  <= r_overflow | w_lost;
            if (i_nib_valid && i_nib_corr && !i_nib_uncorr) r_corr_cnt <= sat_inc(r_corr_cnt);
            else                                            r_corr_cnt <= r_corr_cnt;
            if (w_bad_drop || w_lost) r_drop_cnt <= sat_inc(r_drop_cnt);
            else                      r_drop_cnt <= r_drop_cnt;
        end
    end

    assign o_tx_byte    = r_tx_byte;
    assign o_tx_enable  = r_tx_enable;
    assign o_fifo_level = r_level;
    assign o_overflow   = r_overflow;
    assign o_corr_cnt   = r_corr_cnt;
    assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_nibble_byte_assembler.sv
// Bench for nibble_byte_assembler: three parameter variants share the nibble
// stream, each paced by its own transmitter busy responder.
`timescale 1ns/1ps
module tb_nibble_byte_assembler;

    localparam int BW = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] nib;
    logic       nv, nc, nu, ns;
    logic       busy [3];
    logic [7:0] txb  [3];
    logic       txe  [3];
    logic [2:0] lvl  [3];
    logic       ovf  [3];
    logic [7:0] ccnt [3];
    logic [7:0] dcnt [3];

    always #5 clk = ~clk;

    nibble_byte_assembler #(.LOW_FIRST(1), .FIFO_DEPTH(4), .DROP_BAD(0), .BUSY_WAIT(BW)) u_a (
        .i_clk(clk), .i_reset(rst), .i_nib_in(nib), .i_nib_valid(nv), .i_nib_corr(nc),
        .i_nib_uncorr(nu), .i_nib_sync(ns), .i_tx_busy(busy[0]), .o_tx_byte(txb[0]),
        .o_tx_enable(txe[0]), .o_fifo_level(lvl[0]), .o_overflow(ovf[0]),
        .o_corr_cnt(ccnt[0]), .o_drop_cnt(dcnt[0]));
    nibble_byte_assembler #(.LOW_FIRST(0), .FIFO_DEPTH(4), .DROP_BAD(0), .BUSY_WAIT(BW)) u_b (
        .i_clk(clk), .i_reset(rst), .i_nib_in(nib), .i_nib_valid(nv), .i_nib_corr(nc),
        .i_nib_uncorr(nu), .i_nib_sync(ns), .i_tx_busy(busy[1]), .o_tx_byte(txb[1]),
        .o_tx_enable(txe[1]), .o_fifo_level(lvl[1]), .o_overflow(ovf[1]),
        .o_corr_cnt(ccnt[1]), .o_drop_cnt(dcnt[1]));
    nibble_byte_assembler #(.LOW_FIRST(1), .FIFO_DEPTH(4), .DROP_BAD(1), .BUSY_WAIT(BW)) u_c (
        .i_clk(clk), .i_reset(rst), .i_nib_in(nib), .i_nib_valid(nv), .i_nib_corr(nc),
        .i_nib_uncorr(nu), .i_nib_sync(ns), .i_tx_busy(busy[2]), .o_tx_byte(txb[2]),
        .o_tx_enable(txe[2]), .o_fifo_level(lvl[2]), .o_overflow(ovf[2]),
        .o_corr_cnt(ccnt[2]), .o_drop_cnt(dcnt[2]));

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = 0;   // 0: normal frames, 1: busy stuck high, 2: busy never rises
    int frame_len = 4;
    int rcnt    [3];
    int en_cnt  [3];
    int en_gap  [3];
    int last_en [3];
    int cyc = 0;
    logic [7:0] q0[$], q1[$], q2[$];

    // Transmitter responder and tx_enable monitor for all three instances.
    initial begin
        for (int k = 0; k < 3; k++) begin
            busy[k] = 1'b0; rcnt[k] = 0; en_cnt[k] = 0; en_gap[k] = 0; last_en[k] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 3; k++) begin
                if (txe[k] === 1'b1) begin
                    en_cnt[k]++;
                    en_gap[k]  = cyc - last_en[k];
                    last_en[k] = cyc;
                    if (k == 0) q0.push_back(txb[0]);
                    else if (k == 1) q1.push_back(txb[1]);
                    else q2.push_back(txb[2]);
                end
                if (mode == 1) begin
                    busy[k] = 1'b1; rcnt[k] = 0;
                end else if (mode == 2) begin
                    busy[k] = 1'b0; rcnt[k] = 0;
                end else if (txe[k] === 1'b1) begin
                    rcnt[k] = frame_len; busy[k] = 1'b1;
                end else if (rcnt[k] > 0) begin
                    rcnt[k]--; busy[k] = (rcnt[k] > 0);
                end else begin
                    busy[k] = 1'b0;
                end
            end
        end
    end

    function automatic logic [7:0] qget(input int k, input int i);
        if (k == 0) return (i < q0.size()) ? q0[i] : 8'hxx;
        if (k == 1) return (i < q1.size()) ? q1[i] : 8'hxx;
        return (i < q2.size()) ? q2[i] : 8'hxx;
    endfunction

    task automatic clear_mon();
        #1;
        q0.delete(); q1.delete(); q2.delete();
        for (int k = 0; k < 3; k++) en_cnt[k] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; nib = 4'h0; nv = 1'b0; nc = 1'b0; nu = 1'b0; ns = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic send_nib(input logic [3:0] n, input logic c, input logic u,
                            input logic s, input int gap);
        nib = n; nv = 1'b1; nc = c; nu = u; ns = s;
        @(negedge clk);
        nv = 1'b0; nc = 1'b0; nu = 1'b0; ns = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        mode = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({txb[k], txe[k], lvl[k], ovf[k], ccnt[k], dcnt[k]} !== 28'h0) begin
                n_fail++;
                $display("FAIL reset_state inst%0d: got byte=%h en=%b lvl=%0d ovf=%b corr=%0d drop=%0d, want all 0",
                         k, txb[k], txe[k], lvl[k], ovf[k], ccnt[k], dcnt[k]);
            end
        end
    endtask

    task automatic test_pairing();
        logic [7:0] exp1 [3];
        logic [7:0] exp2 [3];
        exp1 = '{8'hA5, 8'h5A, 8'hA5};
        exp2 = '{8'h3A, 8'hA3, 8'h3A};
        mode = 0; frame_len = 10;
        do_reset();
        send_nib(4'h5, 1'b0, 1'b0, 1'b0, 2);
        send_nib(4'hA, 1'b0, 1'b0, 1'b0, 30);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (en_cnt[k] != 1 || qget(k, 0) !== exp1[k] || txb[k] !== exp1[k]) begin
                n_fail++;
                $display("FAIL pair_basic inst%0d: got %0d enables byte=%h held=%h, want 1 enable byte=%h",
                         k, en_cnt[k], qget(k, 0), txb[k], exp1[k]);
            end
        end
        clear_mon();
        send_nib(4'h5, 1'b0, 1'b0, 1'b0, 1);
        ns = 1'b1; @(negedge clk); ns = 1'b0;
        send_nib(4'hA, 1'b0, 1'b0, 1'b0, 1);
        send_nib(4'h3, 1'b0, 1'b0, 1'b0, 30);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (en_cnt[k] != 1 || qget(k, 0) !== exp2[k] || lvl[k] !== 3'd0) begin
                n_fail++;
                $display("FAIL pair_sync inst%0d: got %0d enables byte=%h lvl=%0d, want 1 enable byte=%h lvl=0",
                         k, en_cnt[k], qget(k, 0), lvl[k], exp2[k]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] ea, eb;
        mode = 1;
        do_reset();
        for (int i = 0; i < 10; i++) send_nib(4'(i + 1), 1'b0, 1'b0, 1'b0, 0);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (lvl[k] !== 3'd4 || ovf[k] !== 1'b1 || dcnt[k] !== 8'd1 || en_cnt[k] != 0) begin
                n_fail++;
                $display("FAIL overflow inst%0d: got lvl=%0d ovf=%b drop=%0d en=%0d, want lvl=4 ovf=1 drop=1 en=0",
                         k, lvl[k], ovf[k], dcnt[k], en_cnt[k]);
            end
        end
        mode = 0; frame_len = 2;
        repeat (60) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (en_cnt[k] != 4 || ovf[k] !== 1'b1 || lvl[k] !== 3'd0) begin
                n_fail++;
                $display("FAIL overflow_drain inst%0d: got en=%0d ovf=%b lvl=%0d, want en=4 ovf=1 lvl=0",
                         k, en_cnt[k], ovf[k], lvl[k]);
            end
            for (int i = 0; i < 4; i++) begin
                ea = {4'(2 * i + 2), 4'(2 * i + 1)};
                eb = {4'(2 * i + 1), 4'(2 * i + 2)};
                n_checks++;
                if (qget(k, i) !== ((k == 1) ? eb : ea)) begin
                    n_fail++;
                    $display("FAIL overflow_order inst%0d byte%0d: got %h, want %h",
                             k, i, qget(k, i), (k == 1) ? eb : ea);
                end
            end
        end
    endtask

    task automatic test_drop_bad();
        mode = 0; frame_len = 3;
        do_reset();
        send_nib(4'h1, 1'b1, 1'b1, 1'b0, 1);
        send_nib(4'h2, 1'b0, 1'b0, 1'b0, 30);
        n_checks++;
        if (en_cnt[0] != 1 || qget(0, 0) !== 8'h21 || dcnt[0] !== 8'd0 || ccnt[0] !== 8'd0) begin
            n_fail++;
            $display("FAIL bad_forward: got en=%0d byte=%h drop=%0d corr=%0d, want en=1 byte=21 drop=0 corr=0",
                     en_cnt[0], qget(0, 0), dcnt[0], ccnt[0]);
        end
        n_checks++;
        if (en_cnt[1] != 1 || qget(1, 0) !== 8'h12) begin
            n_fail++;
            $display("FAIL bad_forward_hi: got en=%0d byte=%h, want en=1 byte=12", en_cnt[1], qget(1, 0));
        end
        n_checks++;
        if (en_cnt[2] != 0 || dcnt[2] !== 8'd1 || lvl[2] !== 3'd0 || ccnt[2] !== 8'd0) begin
            n_fail++;
            $display("FAIL bad_drop: got en=%0d drop=%0d lvl=%0d corr=%0d, want en=0 drop=1 lvl=0 corr=0",
                     en_cnt[2], dcnt[2], lvl[2], ccnt[2]);
        end
    endtask

    task automatic test_busy_timeout();
        int t;
        mode = 2;
        do_reset();
        send_nib(4'h3, 1'b0, 1'b0, 1'b0, 0);
        send_nib(4'hC, 1'b0, 1'b0, 1'b0, 0);
        send_nib(4'h6, 1'b0, 1'b0, 1'b0, 0);
        send_nib(4'h9, 1'b0, 1'b0, 1'b0, 0);
        t = 0;
        while (en_cnt[0] < 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (en_cnt[0] != 2 || qget(0, 0) !== 8'hC3 || qget(0, 1) !== 8'h96) begin
            n_fail++;
            $display("FAIL timeout_send: got en=%0d bytes=%h,%h, want en=2 bytes=c3,96",
                     en_cnt[0], qget(0, 0), qget(0, 1));
        end
        n_checks++;
        if (en_gap[0] != BW + 2) begin
            n_fail++;
            $display("FAIL timeout_gap: got %0d cycles between enables, want %0d", en_gap[0], BW + 2);
        end
        mode = 2;
        do_reset();
        for (int i = 0; i < 300; i++) send_nib(4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (ccnt[k] !== 8'd255 || ovf[k] !== 1'b1 || lvl[k] > 3'd4) begin
                n_fail++;
                $display("FAIL corr_saturate inst%0d: got corr=%0d ovf=%b lvl=%0d, want corr=255 ovf=1 lvl<=4",
                         k, ccnt[k], ovf[k], lvl[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp0[$], exp1[$], exp2[$];
        logic [7:0] e;
        logic [3:0] first_nib, n;
        logic       first_bad, c, u, s;
        int phase, exp_corr, exp_bad, r;
        phase = 0; exp_corr = 0; exp_bad = 0; first_nib = 4'h0; first_bad = 1'b0;
        mode = 0; frame_len = $urandom_range(1, 4);
        do_reset();
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                phase = 0;
                ns = 1'b1; @(negedge clk); ns = 1'b0;
                repeat ($urandom_range(3, 6)) @(negedge clk);
            end else begin
                n = 4'($urandom_range(0, 15));
                c = ($urandom_range(0, 3) == 0);
                u = ($urandom_range(0, 5) == 0);
                s = (r == 1);
                if (c && !u) exp_corr++;
                if (s) phase = 0;
                if (phase == 0) begin
                    first_nib = n; first_bad = u; phase = 1;
                end else begin
                    exp0.push_back({n, first_nib});
                    exp1.push_back({first_nib, n});
                    if (first_bad || u) exp_bad++;
                    else exp2.push_back({n, first_nib});
                    phase = 0;
                end
                send_nib(n, c, u, s, $urandom_range(3, 6));
            end
        end
        repeat (60) @(negedge clk);
        n_checks++;
        if (en_cnt[0] != exp0.size() || en_cnt[1] != exp1.size() || en_cnt[2] != exp2.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d/%0d/%0d frames, want %0d/%0d/%0d",
                     en_cnt[0], en_cnt[1], en_cnt[2], exp0.size(), exp1.size(), exp2.size());
        end
        for (int k = 0; k < 3; k++) begin
            r = (k == 0) ? exp0.size() : (k == 1) ? exp1.size() : exp2.size();
            for (int i = 0; i < r; i++) begin
                e = (k == 0) ? exp0[i] : (k == 1) ? exp1[i] : exp2[i];
                n_checks++;
                if (qget(k, i) !== e) begin
                    n_fail++;
                    $display("FAIL rand_byte inst%0d idx%0d: got %h, want %h", k, i, qget(k, i), e);
                end
            end
            n_checks++;
            if (ccnt[k] !== 8'(exp_corr) || ovf[k] !== 1'b0 ||
                dcnt[k] !== ((k == 2) ? 8'(exp_bad) : 8'd0)) begin
                n_fail++;
                $display("FAIL rand_status inst%0d: got corr=%0d drop=%0d ovf=%b, want corr=%0d drop=%0d ovf=0",
                         k, ccnt[k], dcnt[k], ovf[k], exp_corr, (k == 2) ? exp_bad : 0);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        mode = 0; frame_len = 20;
        do_reset();
        for (int i = 0; i < 6; i++) send_nib(4'(i + 1), 1'b0, 1'b0, 1'b0, 0);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (lvl[k] !== 3'd2 || txb[k] !== ((k == 1) ? 8'h12 : 8'h21) || en_cnt[k] != 1) begin
                n_fail++;
                $display("FAIL mid_frame_setup inst%0d: got lvl=%0d byte=%h en=%0d, want lvl=2 one enable",
                         k, lvl[k], txb[k], en_cnt[k]);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({txb[k], txe[k], lvl[k], ovf[k], ccnt[k], dcnt[k]} !== 28'h0) begin
                n_fail++;
                $display("FAIL mid_frame_reset inst%0d: got byte=%h en=%b lvl=%0d ovf=%b corr=%0d drop=%0d, want all 0",
                         k, txb[k], txe[k], lvl[k], ovf[k], ccnt[k], dcnt[k]);
            end
        end
        mode = 2;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon();
        repeat (40) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (en_cnt[k] != 0 || lvl[k] !== 3'd0) begin
                n_fail++;
                $display("FAIL mid_frame_after inst%0d: got en=%0d lvl=%0d, want en=0 lvl=0", k, en_cnt[k], lvl[k]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; nib = 4'h0; nv = 1'b0; nc = 1'b0; nu = 1'b0; ns = 1'b0;
        test_reset();
        test_pairing();
        test_overflow();
        test_drop_bad();
        test_busy_timeout();
        test_random();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
